// File: rtl/cnn_accelerator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cnn_accelerator
//  Description : 2x2 window convolution with one shared signed weight,
//                followed by ReLU, 2x2 max-pool and unsigned saturation to
//                8 bits. Three registered stages, one new window per cycle.
//  Ports       : clk          - single clock, rising-edge
//                rst          - asynchronous active-low reset
//                input1..4    - unsigned 8-bit pixels of the 2x2 window
//                weight       - signed 8-bit kernel weight (all pixels)
//                final_output - registered unsigned 8-bit result
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_accelerator (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] input1,
    input  logic [7:0] input2,
    input  logic [7:0] input3,
    input  logic [7:0] input4,
    input  logic [7:0] weight,
    output logic [7:0] final_output
);

    localparam int c_LANES = 4;

    logic        [7:0]  w_pix [c_LANES];
    logic signed [16:0] w_wt_ext;
    logic signed [16:0] r_prod [c_LANES];
    logic        [15:0] r_relu [c_LANES];
    logic        [15:0] w_max;
    logic        [7:0]  w_sat;

    assign w_pix[0] = input1;
    assign w_pix[1] = input2;
    assign w_pix[2] = input3;
    assign w_pix[3] = input4;

    // Both multiplicands are widened to 17 bits so the signed product is
    // exact: the extreme magnitudes (255*127, 255*-128) fit in 17 bits.
    assign w_wt_ext = {{9{weight[7]}}, weight};

    // Stage 1: products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_LANES; i++) r_prod[i] <= '0;
        end else begin
            for (int i = 0; i < c_LANES; i++)
                r_prod[i] <= $signed({9'd0, w_pix[i]}) * w_wt_ext;
        end
    end

    // Stage 2: ReLU. A non-negative product never exceeds 32385, so the
    // low 16 bits carry the full value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_LANES; i++) r_relu[i] <= '0;
        end else begin
            for (int i = 0; i < c_LANES; i++)
                r_relu[i] <= r_prod[i][16] ? 16'd0 : r_prod[i][15:0];
        end
    end

    // Stage 3: max-pool and saturate.
    always_comb begin
        w_max = r_relu[0];
        for (int i = 1; i < c_LANES; i++)
            if (r_relu[i] > w_max) w_max = r_relu[i];
    end

    assign w_sat = (w_max > 16'd255) ? 8'd255 : w_max[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) final_output <= '0;
        else      final_output <= w_sat;
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_accelerator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_accelerator
//  Description : Scoreboard bench for cnn_accelerator. The driver pushes the
//                reference result of every applied window; the monitor pops
//                one entry per clock once the pipeline has filled and checks
//                that the output is zero during and right after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_accelerator;

    logic       clk;
    logic       rst;
    logic [7:0] input1, input2, input3, input4, weight;
    logic [7:0] final_output;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int edges_since_rst = 0;

    cnn_accelerator dut (
        .clk          (clk),
        .rst          (rst),
        .input1       (input1),
        .input2       (input2),
        .input3       (input3),
        .input4       (input4),
        .weight       (weight),
        .final_output (final_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: largest non-negative product, clamped to 255.
    function automatic int model(int a, int b, int c, int d, int w);
        int px[4];
        int m;
        px = '{a, b, c, d};
        m  = 0;
        foreach (px[i]) if (px[i] * w > m) m = px[i] * w;
        return (m > 255) ? 255 : m;
    endfunction

    task automatic check(string name, int actual, int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one window on a falling edge and record its expected result.
    task automatic apply(input int a, input int b, input int c, input int d, input int w);
        @(negedge clk);
        rst    = 1'b1;
        input1 = 8'(a);
        input2 = 8'(b);
        input3 = 8'(c);
        input4 = 8'(d);
        weight = 8'(w);
        exp_q.push_back(model(a, b, c, d, int'($signed(8'(w)))));
    endtask

    // Assert reset between edges and check the output clears with no edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_reset_clear", int'(final_output), 0);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: one decision per clock, sampled 1ns after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                exp_q.delete();
                edges_since_rst = 0;
                check("in_reset", int'(final_output), 0);
            end else begin
                edges_since_rst++;
                if (edges_since_rst < 3) begin
                    check("fill_zero", int'(final_output), 0);
                end else if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    check("result", int'(final_output), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        input1 = '0; input2 = '0; input3 = '0; input4 = '0; weight = '0;
        #1;
        check("power_on_reset", int'(final_output), 0);
        repeat (2) @(posedge clk);

        // Held window, expect 24 after the third edge.
        repeat (4) apply(5, 6, 7, 8, 3);
        // Negative and zero weight.
        apply(5, 6, 7, 8, 8'hFF);
        apply(5, 6, 7, 8, 0);
        apply(5, 6, 7, 8, 8'h80);
        // Saturation.
        apply(255, 1, 2, 3, 2);
        apply(255, 255, 255, 255, 127);
        apply(255, 255, 255, 255, 8'h80);
        // Ties and exact boundary.
        apply(85, 85, 85, 85, 3);
        apply(0, 0, 0, 128, 2);
        // Back-to-back sequence 40, 45, 200.
        apply(1, 2, 3, 4, 10);
        apply(9, 0, 0, 0, 5);
        apply(0, 0, 0, 100, 2);

        // Same sequence with reset while two sets are still in flight.
        do_reset();
        apply(1, 2, 3, 4, 10);
        apply(9, 0, 0, 0, 5);
        apply(0, 0, 0, 100, 2);
        do_reset();
        apply(1, 2, 3, 4, 10);
        apply(9, 0, 0, 0, 5);
        apply(0, 0, 0, 100, 2);

        // Randomised windows with extremes favoured.
        for (int n = 0; n < 300; n++) begin
            int px[4];
            int w;
            foreach (px[i]) px[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       w = 127;
                1:       w = 8'h80;
                2:       w = 0;
                3:       w = int'($urandom_range(1, 3));
                default: w = int'($urandom_range(0, 255));
            endcase
            apply(px[0], px[1], px[2], px[3], w);
            if (n == 150) do_reset();
        end

        // Drain the pipeline.
        repeat (3) apply(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
